uart_byte_receiver: RTL and testbench

UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

---
 rtl/uart_byte_receiver.sv | 185 ++++++++++++++++++
 tb/tb_uart_byte_receiver.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, start + PAYLOAD_BITS + stop.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data bits and the stop bit.
module uart_byte_receiver #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rxd,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW             = $clog2(CYCLES_PER_BIT + 1);
  localparam int BW             = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q;
  logic                    rxd_prev_q, rxd_prev_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    rxd_s, fall_s, bit_tick_s, half_tick_s, stop_tick_s, good_s;
`ifdef UART_RX_PARITY_EN
  logic                    par_err_q, par_err_d;
`endif

  assign rxd_s       = sync2_q;
  assign fall_s      = rxd_prev_q & ~rxd_s;
  assign bit_tick_s  = (cnt_q == BIT_LAST);
  assign half_tick_s = (cnt_q == HALF_LAST);
  assign stop_tick_s = (state_q == S_STOP) && bit_tick_s;
`ifdef UART_RX_PARITY_EN
  assign good_s      = rxd_s & ~par_err_q;
`else
  assign good_s      = rxd_s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= uart_rxd;
      sync2_q    <= sync1_q;
      rxd_prev_q <= rxd_prev_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rxd_prev_d = rxd_s;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (fall_s) begin
          state_d = S_START;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (half_tick_s) begin
          cnt_d   = '0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_tick_s) begin
          cnt_d     = '0;
          shift_d   = {rxd_s, shift_q[PAYLOAD_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick_s) begin
          cnt_d     = '0;
          par_err_d = (^shift_q) ^ rxd_s;
          state_d   = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick_s) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          // A low stop bit re-arms edge detection so a held-low break yields one error per frame.
          if (!rxd_s) begin
            rxd_prev_d = 1'b1;
          end else begin
            rxd_prev_d = rxd_s;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valid_d = stop_tick_s & good_s;
    err_d   = stop_tick_s & ~good_s;
    if (valid_d) begin
      data_d = shift_q;
    end else begin
      data_d = data_q;
    end
  end

  assign uart_rx_data      = data_q;
  assign uart_rx_valid     = valid_q;
  assign uart_rx_frame_err = err_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver at a scaled bit rate (160 clocks per bit).
module tb_uart_byte_receiver;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BIT_RATE = 312_500;
  localparam int CPB      = CLK_HZ / BIT_RATE;
`ifdef UART_RX_PARITY_EN
  localparam int LAT      = (19 * CPB) / 2 + 3 + CPB;
`else
  localparam int LAT      = (19 * CPB) / 2 + 3;
`endif

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       lat_chk;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       uart_rx_frame_err;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic       done = 1'b0;

  uart_byte_receiver #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .uart_rxd          (uart_rxd),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_valid     (uart_rx_valid),
    .uart_rx_frame_err (uart_rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic hold(input logic v, input int n);
    uart_rxd = v;
    repeat (n) @(negedge clk);
  endtask

  // Queues the expected response, then drives one frame (start, LSB-first data, [parity], stop).
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip,
                            input logic exp_err, input logic lat);
    exp_t e;
    e.is_err  = exp_err;
    e.data    = exp_err ? last_good : d;
    e.lat_chk = lat;
    e.t0      = cyc;
    exp_q.push_back(e);
    if (!exp_err) last_good = d;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ par_flip, CPB);
`endif
    hold(stop_v, CPB);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 50);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 300);

    hold(1'b0, 60);
    hold(1'b1, 2 * CPB);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    hold(1'b1, 3 * CPB);

    // Break: released just after the second frame error, before the third start sample.
    for (int k = 0; k < 2; k++) begin
      e.is_err = 1'b1; e.data = last_good; e.lat_chk = 1'b0; e.t0 = 0;
      exp_q.push_back(e);
    end
    hold(1'b0, 19 * CPB + 20);
    hold(1'b1, 3 * CPB);

    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 2 * CPB);

    // 0x55 aborted by reset in the middle of data bit 4.
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(i[0] ? 1'b0 : 1'b1, CPB);
    hold(1'b1, CPB / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    hold(1'b1, 20 * CPB);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 2 * CPB);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 2 * CPB);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    hold(1'b1, 2 * CPB);
`endif

    hold(1'b1, 4 * CPB);
    done = 1'b1;
  end

  // Monitor: reset-state checks, then pops and compares one scoreboard entry per output pulse.
  initial begin
    exp_t e;
    logic rst_s;
    while (!done) begin
      @(posedge clk);
      rst_s = rst;
      #1;
      if (rst_s) begin
        n_cmp++;
        if (uart_rx_data !== 8'h00) begin
          n_fail++; $display("FAIL reset_data: got %h expected 00", uart_rx_data);
        end
        n_cmp++;
        if (uart_rx_valid !== 1'b0) begin
          n_fail++; $display("FAIL reset_valid: got %b expected 0", uart_rx_valid);
        end
        n_cmp++;
        if (uart_rx_frame_err !== 1'b0) begin
          n_fail++; $display("FAIL reset_err: got %b expected 0", uart_rx_frame_err);
        end
      end else if (uart_rx_valid || uart_rx_frame_err) begin
        n_cmp++;
        if (uart_rx_valid && uart_rx_frame_err) begin
          n_fail++; $display("FAIL both_pulses: valid=1 err=1 at cycle %0d expected exclusive", cyc);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: valid=%b err=%b data=%h at cycle %0d expected none",
                   uart_rx_valid, uart_rx_frame_err, uart_rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (uart_rx_frame_err !== e.is_err || uart_rx_data !== e.data) begin
            n_fail++;
            $display("FAIL pulse: got err=%b data=%h expected err=%b data=%h",
                     uart_rx_frame_err, uart_rx_data, e.is_err, e.data);
          end
          if (e.lat_chk) begin
            n_cmp++;
            if ((cyc - e.t0) < LAT - 1 || (cyc - e.t0) > LAT + 1) begin
              n_fail++; $display("FAIL latency: got %0d expected %0d +-1", cyc - e.t0, LAT);
            end
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_pulses: got %0d outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
